// File: rtl/axi4_r_return_router_if.sv
// -----------------------------------------------------------------------------
// axi4_r_return_router_if
//   AXI4 read-data (R) channel bundle for a group of N ports.
//   Each signal is an unpacked array indexed [0:N-1], one element per port.
//
//   Modports (named by AXI role; R data flows from slave to master):
//     slave  : drives RID/RDATA/RSTRB/RLAST/RVALID, receives RREADY.
//     master : receives RID/RDATA/RSTRB/RLAST/RVALID, drives RREADY.
//
//   Parameters:
//     N      : number of ports in the bundle
//     ID_W   : RID width
//     DATA_W : RDATA width (RSTRB is DATA_W/8)
// -----------------------------------------------------------------------------
interface axi4_r_return_router_if #(
  parameter int N      = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   RID    [0:N-1];
  logic [DATA_W-1:0] RDATA  [0:N-1];
  logic [STRB_W-1:0] RSTRB  [0:N-1];
  logic              RLAST  [0:N-1];
  logic              RVALID [0:N-1];
  logic              RREADY [0:N-1];

  modport slave (
    output RID, RDATA, RSTRB, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    input  RID, RDATA, RSTRB, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_r_return_router.sv
// -----------------------------------------------------------------------------
// axi4_r_return_router
//   Routes AXI4 R beats from SLAVE_NUM slave-side ports back to MASTER_NUM
//   master-side ports. The top EXTRA_ID_LEN bits of each slave RID select the
//   destination master; those bits are stripped before the beat is forwarded.
//
//   Per master there is one arbiter and one R_BUF_DEPTH-beat FIFO:
//     - The arbiter is IDLE (round-robin from rr_ptr) or LOCKED to one slave
//       until that slave's RLAST, so bursts are never interleaved.
//     - Grant is combinational; an accepted beat is visible on the master
//       port on the next cycle when the FIFO was empty.
//     - s.RREADY depends only on arbiter state, requests and FIFO fullness,
//       never on m.RREADY (a full FIFO stalls even if it pops this cycle).
//
//   Ports:
//     ACLK   : clock, all state on the rising edge
//     ARESET : asynchronous active-high reset
//     s      : slave-side R bundle (router is the R sink), SLAVE_NUM ports,
//              RID width EXTRA_ID_LEN+R_ID_LEN
//     m      : master-side R bundle (router is the R source), MASTER_NUM
//              ports, RID width R_ID_LEN
// -----------------------------------------------------------------------------
module axi4_r_return_router #(
  parameter int MASTER_NUM   = 4,
  parameter int SLAVE_NUM    = 4,
  parameter int R_ID_LEN     = 4,
  parameter int EXTRA_ID_LEN = $clog2(MASTER_NUM),
  parameter int DATA_WIDTH   = 64,
  parameter int R_BUF_DEPTH  = 2
) (
  input logic                     ACLK,
  input logic                     ARESET,
  axi4_r_return_router_if.master  s,
  axi4_r_return_router_if.slave   m
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int S_ID_LEN = EXTRA_ID_LEN + R_ID_LEN;
  localparam int SIDX_W   = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int PTR_W    = (R_BUF_DEPTH > 1) ? $clog2(R_BUF_DEPTH) : 1;
  localparam int CNT_W    = $clog2(R_BUF_DEPTH + 1);

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [R_ID_LEN-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
    logic                  last;
  } beat_t;

  // (base + off) mod SLAVE_NUM, for off in 0..SLAVE_NUM-1
  function automatic logic [SIDX_W-1:0] wrap_add(input logic [SIDX_W-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= SLAVE_NUM) sum = sum - SLAVE_NUM;
    return SIDX_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(R_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode: slave i requests master mi when valid and prefix == mi.
  // A prefix >= MASTER_NUM matches no master, so that beat simply stalls.
  // ---------------------------------------------------------------------------
  logic [EXTRA_ID_LEN-1:0] prefix [SLAVE_NUM];
  logic [SLAVE_NUM-1:0]    req    [MASTER_NUM];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    for (int i = 0; i < SLAVE_NUM; i++) begin
      prefix[i] = s.RID[i][S_ID_LEN-1 -: EXTRA_ID_LEN];
    end
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      req[mi] = '0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
        req[mi][i] = s.RVALID[i] && (prefix[i] == EXTRA_ID_LEN'(mi));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter state and FIFO state
  // ---------------------------------------------------------------------------
  arb_state_e        state_q [MASTER_NUM];
  arb_state_e        state_d [MASTER_NUM];
  logic [SIDX_W-1:0] lock_q  [MASTER_NUM];
  logic [SIDX_W-1:0] lock_d  [MASTER_NUM];
  logic [SIDX_W-1:0] rr_q    [MASTER_NUM];
  logic [SIDX_W-1:0] rr_d    [MASTER_NUM];

  logic              gnt_vld [MASTER_NUM];
  logic [SIDX_W-1:0] gnt_idx [MASTER_NUM];
  beat_t             in_beat [MASTER_NUM];

  beat_t             mem     [MASTER_NUM][R_BUF_DEPTH];
  logic [PTR_W-1:0]  wr_q    [MASTER_NUM];
  logic [PTR_W-1:0]  rd_q    [MASTER_NUM];
  logic [CNT_W-1:0]  count_q [MASTER_NUM];
  logic              full    [MASTER_NUM];
  logic              empty   [MASTER_NUM];
  logic              push    [MASTER_NUM];
  logic              pop     [MASTER_NUM];
  beat_t             head    [MASTER_NUM];

  // ---------------------------------------------------------------------------
  // Grant: LOCKED serves only its owner; IDLE picks the first requester at or
  // after rr_ptr. The scan runs from the farthest offset down so the nearest
  // requester is the last (winning) assignment.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      gnt_vld[mi] = 1'b0;
      gnt_idx[mi] = '0;
      if (state_q[mi] == ARB_LOCKED) begin
        if (req[mi][lock_q[mi]]) begin
          gnt_vld[mi] = 1'b1;
          gnt_idx[mi] = lock_q[mi];
        end
      end else begin
        for (int k = SLAVE_NUM - 1; k >= 0; k--) begin
          if (req[mi][wrap_add(rr_q[mi], k)]) begin
            gnt_vld[mi] = 1'b1;
            gnt_idx[mi] = wrap_add(rr_q[mi], k);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes. Push is held off during reset so nothing is accepted or
  // written while ARESET is high. Full alone blocks a push (no same-cycle
  // pop bypass), which keeps s.RREADY independent of m.RREADY.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      full[mi]         = (count_q[mi] == CNT_W'(R_BUF_DEPTH));
      empty[mi]        = (count_q[mi] == '0);
      push[mi]         = gnt_vld[mi] && !full[mi] && !ARESET;
      pop[mi]          = !empty[mi] && m.RREADY[mi];
      in_beat[mi].id   = s.RID[gnt_idx[mi]][R_ID_LEN-1:0];
      in_beat[mi].data = s.RDATA[gnt_idx[mi]];
      in_beat[mi].strb = s.RSTRB[gnt_idx[mi]];
      in_beat[mi].last = s.RLAST[gnt_idx[mi]];
    end
  end

  // A slave is requested by at most one master (its prefix), so OR-ing the
  // per-master pushes back onto slave indices never conflicts.
  always_comb begin
    for (int i = 0; i < SLAVE_NUM; i++) begin
      s.RREADY[i] = 1'b0;
      for (int mi = 0; mi < MASTER_NUM; mi++) begin
        if (push[mi] && (gnt_idx[mi] == SIDX_W'(i))) s.RREADY[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      state_d[mi] = state_q[mi];
      lock_d[mi]  = lock_q[mi];
      rr_d[mi]    = rr_q[mi];
      if (push[mi]) begin
        if (state_q[mi] == ARB_IDLE) begin
          if (in_beat[mi].last) begin
            rr_d[mi] = wrap_add(gnt_idx[mi], 1);
          end else begin
            state_d[mi] = ARB_LOCKED;
            lock_d[mi]  = gnt_idx[mi];
          end
        end else if (in_beat[mi].last) begin
          state_d[mi] = ARB_IDLE;
          rr_d[mi]    = wrap_add(lock_q[mi], 1);
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (ARESET) begin
      for (int mi = 0; mi < MASTER_NUM; mi++) begin
        state_q[mi] <= ARB_IDLE;
        lock_q[mi]  <= '0;
        rr_q[mi]    <= '0;
      end
    end else begin
      for (int mi = 0; mi < MASTER_NUM; mi++) begin
        state_q[mi] <= state_d[mi];
        lock_q[mi]  <= lock_d[mi];
        rr_q[mi]    <= rr_d[mi];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-master FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int mi = 0; mi < MASTER_NUM; mi++) begin
        wr_q[mi]    <= '0;
        rd_q[mi]    <= '0;
        count_q[mi] <= '0;
      end
    end else begin
      for (int mi = 0; mi < MASTER_NUM; mi++) begin
        if (push[mi]) wr_q[mi] <= ptr_inc(wr_q[mi]);
        if (pop[mi])  rd_q[mi] <= ptr_inc(rd_q[mi]);
        if (push[mi] && !pop[mi]) begin
          count_q[mi] <= count_q[mi] + CNT_W'(1);
        end else if (!push[mi] && pop[mi]) begin
          count_q[mi] <= count_q[mi] - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the beat storage is deliberately not reset; count_q alone says
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge ACLK) begin
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      if (push[mi]) mem[mi][wr_q[mi]] <= in_beat[mi];
    end
  end

  // ---------------------------------------------------------------------------
  // Master-side outputs straight from the FIFO head; the head only moves on a
  // pop, so the payload holds while RVALID is high and RREADY is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int mi = 0; mi < MASTER_NUM; mi++) begin
      head[mi]      = mem[mi][rd_q[mi]];
      m.RVALID[mi]  = !empty[mi];
      m.RID[mi]     = head[mi].id;
      m.RDATA[mi]   = head[mi].data;
      m.RSTRB[mi]   = head[mi].strb;
      m.RLAST[mi]   = head[mi].last;
    end
  end

endmodule

// File: doc/axi4_r_return_router.md
AXI4_R_RETURN_ROUTER -- requirements
Module: axi4_r_return_router

Interface
REQ-001 Parameter MASTER_NUM, default 4: number of master-side R ports.
REQ-002 Parameter SLAVE_NUM, default 4: number of slave-side R ports.
REQ-003 Parameter R_ID_LEN, default 4: master-side RID width.
REQ-004 Parameter EXTRA_ID_LEN, default $clog2(MASTER_NUM): routing-prefix width in slave-side RID.
REQ-005 Parameter DATA_WIDTH, default 64: RDATA width; RSTRB is DATA_WIDTH/8.
REQ-006 Parameter R_BUF_DEPTH, default 2: per-master return FIFO depth in beats.
REQ-007 ACLK  input  1  single clock; all state on rising edge.
REQ-008 ARESET  input  1  reset, asynchronous, active-high.
REQ-009 s_RID  input  [EXTRA_ID_LEN+R_ID_LEN] x SLAVE_NUM  slave RID; MSB EXTRA_ID_LEN bits = destination master index.
REQ-010 s_RDATA / s_RSTRB / s_RLAST / s_RVALID  input  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1, x SLAVE_NUM  slave R payload and valid.
REQ-011 s_RREADY  output  1 x SLAVE_NUM  ready to slave.
REQ-012 m_RID  output  [R_ID_LEN] x MASTER_NUM  prefix-stripped RID.
REQ-013 m_RDATA / m_RSTRB / m_RLAST / m_RVALID  output  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1, x MASTER_NUM  master R payload and valid.
REQ-014 m_RREADY  input  1 x MASTER_NUM  ready from master.
REQ-015 All per-port signals are unpacked arrays indexed [0 : NUM-1].

Function
REQ-016 Each slave beat is routed to master m = s_RID[s][top EXTRA_ID_LEN bits]; prefix >= MASTER_NUM never asserts s_RREADY (beat stalls).
REQ-017 One arbiter per master m; requesters are slaves with s_RVALID=1 and prefix=m.
REQ-018 Arbiter FSM states: IDLE, LOCKED(idx).
REQ-019 IDLE: grant = first requester at or after rr_ptr[m], wrapping modulo SLAVE_NUM; grant is combinational, accept possible in the same cycle.
REQ-020 LOCKED(idx): only slave idx is granted, regardless of other requesters.
REQ-021 Accept on granted slave s: s_RVALID=1 and FIFO[m] not full; s_RREADY[s] = granted and FIFO[m] not full.
REQ-022 IDLE accept with RLAST=0 -> LOCKED(s); with RLAST=1 -> stay IDLE, rr_ptr[m] = (s+1) mod SLAVE_NUM.
REQ-023 LOCKED(idx) accept with RLAST=1 -> IDLE, rr_ptr[m] = (idx+1) mod SLAVE_NUM; RLAST=0 stays LOCKED.
REQ-024 Accepted beat pushes {RID low R_ID_LEN bits, RDATA, RSTRB, RLAST} into FIFO[m].
REQ-025 m_RVALID[m] = FIFO[m] not empty; m_R* = FIFO head; pop when m_RVALID and m_RREADY.
REQ-026 Latency: beat accepted in cycle n appears on m_R* in cycle n+1 if FIFO was empty.
REQ-027 Full: s_RREADY deasserted even if a pop occurs same cycle (no full bypass).
REQ-028 Simultaneous push and pop on non-full, non-empty FIFO: count unchanged, order preserved.
REQ-029 m_R* payload stable while m_RVALID=1 and m_RREADY=0.
REQ-030 Pointers wrap modulo R_BUF_DEPTH; count width holds 0..R_BUF_DEPTH.
REQ-031 s_RREADY has no combinational dependence on m_RREADY.

Reset
REQ-032 ARESET=1 asynchronously: all FIFOs empty, m_RVALID=0, s_RREADY=0, arbiters IDLE, rr_ptr=0.
REQ-033 Reset mid-burst discards buffered and in-flight beats; no partial burst emitted after release.
REQ-034 First accept possible on first ACLK rising edge after ARESET deasserts.

Verification
REQ-035 Single beat: slave 2, RID=0x35, RLAST=1, m_RREADY[3]=1 -> next cycle m_RVALID[3]=1, m_RID[3]=0x5, RLAST=1.
REQ-036 Contention: slaves 0 and 1 each 4-beat burst to master 0 -> slave 0 beats 0-3 contiguous, then slave 1; next contention favours slave 1 (rr_ptr=1... then 2).
REQ-037 Backpressure: m_RREADY[1]=0, 3-beat burst -> 2 beats accepted, s_RREADY=0 thereafter; after release, all 3 delivered in order.
REQ-038 Parallel: slaves 0-3 each target distinct masters 3,2,1,0 -> all four accepted same cycle.
REQ-039 ARESET pulse after beat 2 of 4-beat burst -> m_RVALID=0 all ports, arbiter IDLE, rr_ptr=0.
